// File: rtl/rtc_mux_bus_master_pkg.sv
// Shared state encoding, default timing and width helpers for the
// multiplexed address/data RTC bus master.
package rtc_mux_bus_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_GAP1 = 3'd2,
        ST_DATA = 3'd3,
        ST_GAP2 = 3'd4
    } bus_state_t;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_T_ADDR     = 4;
    localparam int DEF_T_DATA     = 4;
    localparam int DEF_T_GAP      = 2;
    localparam int DEF_FIFO_DEPTH = 4;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) width++;
        return width;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rtc_cmd_fifo.sv
// Small synchronous command FIFO; pointers carry an extra wrap bit so
// full and empty come straight from the registered pointers.
module rtc_cmd_fifo
    import rtc_mux_bus_master_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = clog2(DEPTH);

    if (DEPTH < 2 || (1 << PTR_W) != DEPTH) begin : g_bad_depth
        $error("rtc_cmd_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)  wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop  && !empty) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[PTR_W-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[PTR_W-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/rtc_mux_bus_master.sv
// Queued bus master for multiplexed address/data RTC chips: runs commands
// through ADDR/GAP1/DATA/GAP2 phases with registered strobes and bus enable.
module rtc_mux_bus_master
    import rtc_mux_bus_master_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int T_ADDR     = DEF_T_ADDR,
    parameter int T_DATA     = DEF_T_DATA,
    parameter int T_GAP      = DEF_T_GAP,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              CS,
    output logic              AD,
    output logic              RD,
    output logic              WR,
    inout  wire  [DATA_W-1:0] DatAdd
);

    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = clog2(max3(T_ADDR, T_DATA, T_GAP) + 1);

    if (ADDR_W > DATA_W) begin : g_bad_addr_w
        $error("rtc_mux_bus_master: ADDR_W must not exceed DATA_W");
    end
    if (T_ADDR < 1 || T_DATA < 1 || T_GAP < 1) begin : g_bad_timing
        $error("rtc_mux_bus_master: phase lengths must be at least 1");
    end

    bus_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic               cur_write;
    logic [DATA_W-1:0]  cur_wdata;
    logic               bus_oe;
    logic [DATA_W-1:0]  bus_out;

    logic [ENTRY_W-1:0] fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               phase_done;
    logic               head_write;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_wdata;

    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && cmd_ready;
    assign phase_done = (cnt == CNT_W'(1));
    assign pop        = !fifo_empty &&
                        ((state == ST_IDLE) || (state == ST_GAP2 && phase_done));
    assign busy       = (state != ST_IDLE) || !fifo_empty;
    assign {head_write, head_addr, head_wdata} = fifo_rdata;

    assign DatAdd = bus_oe ? bus_out : 'z;

    rtc_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({cmd_write, cmd_addr, cmd_wdata}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Outputs are computed for the state being entered, so strobes change
    // on the same edge as the state and never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cur_write <= 1'b0;
            cur_wdata <= '0;
            CS        <= 1'b1;
            AD        <= 1'b1;
            RD        <= 1'b1;
            WR        <= 1'b1;
            bus_oe    <= 1'b0;
            bus_out   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (state != ST_IDLE && !phase_done) cnt <= cnt - CNT_W'(1);

            case (state)
                ST_IDLE: ;
                ST_ADDR: if (phase_done) begin
                    state   <= ST_GAP1;
                    cnt     <= CNT_W'(T_GAP);
                    CS      <= 1'b1;
                    AD      <= 1'b1;
                    WR      <= 1'b1;
                    bus_oe  <= cur_write;
                    bus_out <= cur_wdata;
                end
                ST_GAP1: if (phase_done) begin
                    state <= ST_DATA;
                    cnt   <= CNT_W'(T_DATA);
                    CS    <= 1'b0;
                    RD    <= cur_write;
                    WR    <= !cur_write;
                end
                ST_DATA: if (phase_done) begin
                    state  <= ST_GAP2;
                    cnt    <= CNT_W'(T_GAP);
                    CS     <= 1'b1;
                    RD     <= 1'b1;
                    WR     <= 1'b1;
                    bus_oe <= 1'b0;
                    if (!cur_write) begin
                        rsp_data  <= DatAdd;
                        rsp_valid <= 1'b1;
                    end
                end
                ST_GAP2: if (phase_done) begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase

            // A pop overrides the case above: from IDLE or the last GAP2
            // cycle we go straight into the next address phase.
            if (pop) begin
                state     <= ST_ADDR;
                cnt       <= CNT_W'(T_ADDR);
                cur_write <= head_write;
                cur_wdata <= head_wdata;
                CS        <= 1'b0;
                AD        <= 1'b0;
                RD        <= 1'b1;
                WR        <= 1'b0;
                bus_oe    <= 1'b1;
                bus_out   <= DATA_W'(head_addr);
            end
        end
    end

endmodule

// File: tb/tb_rtc_mux_bus_master.sv
// Directed bench for rtc_mux_bus_master: default instance plus a fast-timing
// instance; an undriven bus reads 0xFF through the pullups.
`timescale 1ns/1ps
module tb_rtc_mux_bus_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    int         vectors;
    int         miscompares;
    int         wait_cnt;
    logic [7:0] last_rsp;

    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       rsp_valid, busy, cs, ad, rd, wr;
    logic [7:0] rsp_data;
    logic [7:0] model_data;
    wire  [7:0] dat_add;
    wire  [3:0] strb1 = {cs, ad, rd, wr};

    logic       cmd_valid2, cmd_ready2, cmd_write2;
    logic [5:0] cmd_addr2;
    logic [7:0] cmd_wdata2;
    logic       rsp_valid2, busy2, cs2, ad2, rd2, wr2;
    logic [7:0] rsp_data2;
    wire  [7:0] dat_add2;
    wire  [3:0] strb2 = {cs2, ad2, rd2, wr2};

    // The RTC model answers reads only while the DUT holds RD low.
    assign dat_add = rd ? 8'hzz : model_data;
    pullup (dat_add);
    pullup (dat_add2);

    rtc_mux_bus_master u_dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .CS(cs), .AD(ad), .RD(rd), .WR(wr), .DatAdd(dat_add)
    );

    rtc_mux_bus_master #(
        .DATA_W(8), .ADDR_W(6), .T_ADDR(1), .T_DATA(2), .T_GAP(1), .FIFO_DEPTH(4)
    ) u_dut_fast (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_write(cmd_write2),
        .cmd_addr(cmd_addr2), .cmd_wdata(cmd_wdata2),
        .rsp_valid(rsp_valid2), .rsp_data(rsp_data2), .busy(busy2),
        .CS(cs2), .AD(ad2), .RD(rd2), .WR(wr2), .DatAdd(dat_add2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // Called on a negedge; returns on the negedge right after the push edge.
    task automatic applyStimulus(input bit sel, input bit w, input logic [7:0] a,
                                 input logic [7:0] d);
        int waited;
        waited = 0;
        if (sel) begin
            cmd_write2 = w; cmd_addr2 = a[5:0]; cmd_wdata2 = d; cmd_valid2 = 1'b1;
        end else begin
            cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        end
        while (!(sel ? cmd_ready2 : cmd_ready) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) checkOutput("push_timeout", 32'd0, 32'd1);
        @(negedge clk);
        cmd_valid  = 1'b0;
        cmd_valid2 = 1'b0;
    endtask

    // Checks one full transaction, starting with the first ADDR cycle at the next negedge.
    task automatic runCommandTrace(input string tag, input bit sel, input bit w,
                                   input logic [7:0] a, input logic [7:0] d,
                                   input logic [7:0] rdata,
                                   input int ta, input int td, input int tg);
        logic [3:0] exp_strb;
        logic [7:0] exp_bus;
        logic       exp_rv;
        for (int k = 0; k < ta + td + 2*tg; k++) begin
            @(negedge clk);
            if (k < ta) begin
                exp_strb = 4'b0010; exp_bus = a;
            end else if (k < ta + tg) begin
                exp_strb = 4'b1111; exp_bus = w ? d : 8'hFF;
            end else if (k < ta + tg + td) begin
                exp_strb = w ? 4'b0110 : 4'b0101; exp_bus = w ? d : rdata;
            end else begin
                exp_strb = 4'b1111; exp_bus = 8'hFF;
            end
            exp_rv = !w && (k == ta + tg + td);
            checkOutput($sformatf("%s_strobes_c%0d", tag, k), sel ? strb2 : strb1, exp_strb);
            checkOutput($sformatf("%s_bus_c%0d", tag, k), sel ? dat_add2 : dat_add, exp_bus);
            checkOutput($sformatf("%s_rsp_valid_c%0d", tag, k), sel ? rsp_valid2 : rsp_valid, exp_rv);
            if (exp_rv && !sel) begin
                last_rsp = rdata;
                checkOutput($sformatf("%s_rsp_data", tag), rsp_data, rdata);
            end
        end
        if (!sel) checkOutput($sformatf("%s_rsp_hold", tag), rsp_data, last_rsp);
    endtask

    task automatic runSingle(input string tag, input bit sel, input bit w,
                             input logic [7:0] a, input logic [7:0] d,
                             input logic [7:0] rdata,
                             input int ta, input int td, input int tg);
        if (!sel) model_data = rdata;
        applyStimulus(sel, w, a, d);
        checkOutput({tag, "_idle_strobes"}, sel ? strb2 : strb1, 4'hF);
        checkOutput({tag, "_busy_queued"}, sel ? busy2 : busy, 1'b1);
        runCommandTrace(tag, sel, w, a, d, rdata, ta, td, tg);
        @(negedge clk);
        checkOutput({tag, "_busy_done"}, sel ? busy2 : busy, 1'b0);
        checkOutput({tag, "_strobes_done"}, sel ? strb2 : strb1, 4'hF);
    endtask

    logic [7:0] b_addr [5];
    logic [7:0] b_data [5];
    bit         m_w    [3];
    logic [7:0] m_addr [3];
    logic [7:0] m_data [3];
    logic [7:0] m_rd   [3];

    initial begin
        vectors = 0; miscompares = 0; last_rsp = 8'h00; model_data = 8'h00;
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_valid2 = 1'b0; cmd_write2 = 1'b0; cmd_addr2 = '0; cmd_wdata2 = '0;
        b_addr = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        b_data = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hE4};
        m_w    = '{1'b0, 1'b1, 1'b0};
        m_addr = '{8'h0C, 8'h0B, 8'h0C};
        m_data = '{8'h00, 8'h80, 8'h00};
        m_rd   = '{8'h11, 8'h00, 8'h22};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("rst_ready", cmd_ready, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_strobes", strb1, 4'hF);
        checkOutput("rst_bus", dat_add, 8'hFF);
        checkOutput("rst_rsp_valid", rsp_valid, 1'b0);
        checkOutput("rst_rsp_data", rsp_data, 8'h00);
        checkOutput("rst_fast_strobes", strb2, 4'hF);

        runSingle("wr21", 1'b0, 1'b1, 8'h21, 8'h5A, 8'h00, 4, 4, 2);

        runSingle("rd24", 1'b0, 1'b0, 8'h24, 8'h00, 8'h37, 4, 4, 2);
        repeat (3) @(negedge clk);
        checkOutput("rd24_rsp_late", rsp_data, 8'h37);
        checkOutput("rd24_no_repulse", rsp_valid, 1'b0);

        fork
            begin
                for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, b_addr[i], b_data[i]);
                checkOutput("burst_ready_full", cmd_ready, 1'b0);
                wait_cnt = 0;
                while (!cmd_ready && wait_cnt < 50) begin
                    @(negedge clk);
                    wait_cnt++;
                end
                checkOutput("burst_ready_rise", wait_cnt, 9);
            end
            begin
                @(negedge clk);
                for (int i = 0; i < 5; i++)
                    runCommandTrace($sformatf("burst%0d", i), 1'b0, 1'b1,
                                    b_addr[i], b_data[i], 8'h00, 4, 4, 2);
            end
        join
        @(negedge clk);
        checkOutput("burst_busy_done", busy, 1'b0);
        checkOutput("burst_strobes_done", strb1, 4'hF);

        fork
            begin
                for (int j = 0; j < 3; j++) applyStimulus(1'b0, m_w[j], m_addr[j], m_data[j]);
            end
            begin
                @(negedge clk);
                for (int j = 0; j < 3; j++) begin
                    model_data = m_rd[j];
                    runCommandTrace($sformatf("rwr%0d", j), 1'b0, m_w[j],
                                    m_addr[j], m_data[j], m_rd[j], 4, 4, 2);
                end
            end
        join
        @(negedge clk);
        checkOutput("rwr_busy_done", busy, 1'b0);
        checkOutput("rwr_rsp_final", rsp_data, 8'h22);

        model_data = 8'h66;
        applyStimulus(1'b0, 1'b0, 8'h30, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h31, 8'hA5);
        repeat (7) @(negedge clk);
        checkOutput("abort_in_data", strb1, 4'b0101);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_strobes", strb1, 4'hF);
        checkOutput("abort_bus", dat_add, 8'hFF);
        checkOutput("abort_rsp_valid", rsp_valid, 1'b0);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_ready", cmd_ready, 1'b1);
        checkOutput("abort_rsp_data", rsp_data, 8'h00);
        reset = 1'b0;
        last_rsp = 8'h00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("abort_quiet_rv%0d", k), rsp_valid, 1'b0);
            checkOutput($sformatf("abort_quiet_strb%0d", k), strb1, 4'hF);
        end
        runSingle("after_abort", 1'b0, 1'b1, 8'h2A, 8'h99, 8'h00, 4, 4, 2);

        runSingle("fast_wr3F", 1'b1, 1'b1, 8'h3F, 8'hC3, 8'h00, 1, 2, 1);
        checkOutput("fast_rsp_data", rsp_data2, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
